// File: rtl/lcd_pkg.sv
// Shared types, opcodes and power-on table for the LCD 4-bit bus scheduler.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_GAP,
      ST_WAIT
   } state_t;

   // Byte-level sequencing; nibble phases live in lcd_nibble_strobe.
   typedef enum logic [2:0] {
      SEQ_INIT,
      SEQ_IDLE,
      SEQ_HI,
      SEQ_LO,
      SEQ_WAIT
   } seq_t;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_byte_t;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   localparam logic [3:0]  INIT_NIB0    = 4'h3;
   localparam logic [3:0]  INIT_NIB1    = 4'h2;
   localparam logic [7:0]  INIT_CMD     = 8'h0E;
   localparam int unsigned INIT_NIBBLES = 4;

   function automatic logic [3:0] init_nibble(input logic [1:0] idx);
      case (idx)
         2'd0:    return INIT_NIB0;
         2'd1:    return INIT_NIB1;
         2'd2:    return INIT_CMD[7:4];
         default: return INIT_CMD[3:0];
      endcase
   endfunction

   // Clear and home need the long settle time after the byte.
   function automatic logic is_long_cmd(input lcd_byte_t b);
      return !b.rs && ((b.data == CMD_CLEAR) || (b.data == CMD_HOME));
   endfunction

   // The shared counter must hold the long wait and any 8-bit strobe/gap load.
   function automatic int unsigned cnt_width(input int unsigned long_wait);
      return ($clog2(long_wait + 1) > 8) ? $clog2(long_wait + 1) : 8;
   endfunction

endpackage

// File: rtl/lcd_bus_scheduler_if.sv
// Two-requester byte handshake between clients and the LCD bus scheduler.
interface lcd_bus_scheduler_if;

   logic       req0_valid;
   logic       req0_rs;
   logic [7:0] req0_data;
   logic       req0_ready;

   logic       req1_valid;
   logic       req1_rs;
   logic [7:0] req1_data;
   logic       req1_ready;

   modport master (
      output req0_valid, req0_rs, req0_data,
      output req1_valid, req1_rs, req1_data,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_valid, req0_rs, req0_data,
      input  req1_valid, req1_rs, req1_data,
      output req0_ready, req1_ready
   );

endinterface

// File: rtl/lcd_nibble_strobe.sv
// One-nibble SETUP/STROBE/GAP timing engine; its down-counter also times the post-byte WAIT.
module lcd_nibble_strobe
   import lcd_pkg::*;
#(
   parameter int unsigned E_HIGH_CYCLES    = 4,
   parameter int unsigned GAP_CYCLES       = 8,
   parameter int unsigned LONG_WAIT_CYCLES = 64,
   parameter int unsigned CNT_W            = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] nib,
   input  logic       nib_rs,
   input  logic       wait_start,
   output logic [3:0] lcd_d,
   output logic       lcd_rs,
   output logic       lcd_e,
   output logic       done_c
);

   state_t           phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cnt_zero_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter saturates at zero; each phase reloads it on entry.
   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_zero_c ? cnt_q : (cnt_q - CNT_W'(1));
      case (phase_q)
         ST_SETUP: begin
            phase_d = ST_STROBE;
            cnt_d   = CNT_W'(E_HIGH_CYCLES - 1);
         end
         ST_STROBE: if (cnt_zero_c) begin
            phase_d = ST_GAP;
            cnt_d   = CNT_W'(GAP_CYCLES - 1);
         end
         ST_GAP, ST_WAIT: if (cnt_zero_c) phase_d = ST_IDLE;
         default: ;
      endcase
      if (wait_start) begin
         phase_d = ST_WAIT;
         cnt_d   = CNT_W'(LONG_WAIT_CYCLES - 1);
      end
      if (start) begin
         phase_d = ST_SETUP;
         cnt_d   = '0;
      end
   end

   always_comb begin
      cnt_zero_c = (cnt_q == '0);
      done_c     = cnt_zero_c && ((phase_q == ST_GAP) || (phase_q == ST_WAIT));
   end

   // Nibble and rs are loaded on start and held until the next start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcd_d  <= '0;
         lcd_rs <= 1'b0;
         lcd_e  <= 1'b0;
      end else begin
         lcd_e <= (phase_d == ST_STROBE);
         if (start) begin
            lcd_d  <= nib;
            lcd_rs <= nib_rs;
         end
      end
   end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Round-robin two-requester scheduler driving an HD44780-style 4-bit LCD bus.
// Define LCD_SCHED_INIT_EN to run the power-on nibble sequence after reset.
module lcd_bus_scheduler
   import lcd_pkg::*;
#(
   parameter int unsigned E_HIGH_CYCLES    = 4,
   parameter int unsigned GAP_CYCLES       = 8,
   parameter int unsigned LONG_WAIT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   lcd_bus_scheduler_if.slave  req,
   output logic [3:0]          lcd_d,
   output logic                lcd_rs,
   output logic                lcd_e,
   output logic                busy,
   output logic                init_done
);

   localparam int unsigned CNT_W = cnt_width(LONG_WAIT_CYCLES);

`ifdef LCD_SCHED_INIT_EN
   localparam seq_t SEQ_RESET = SEQ_INIT;
   logic [2:0] init_idx_q;
   logic       init_done_q;
`else
   localparam seq_t SEQ_RESET = SEQ_IDLE;
`endif

   seq_t       seq_q, seq_d;
   lcd_byte_t  byte_q;
   logic       last_q;
   logic       grant0_c, grant1_c, accept_c;
   logic       start_c, wait_start_c, nib_rs_c, done_c;
   logic [3:0] nib_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) seq_q <= SEQ_RESET;
      else        seq_q <= seq_d;
   end

   always_comb begin
      seq_d = seq_q;
      case (seq_q)
`ifdef LCD_SCHED_INIT_EN
         SEQ_INIT: if (done_c && (init_idx_q == 3'(INIT_NIBBLES))) seq_d = SEQ_IDLE;
`endif
         SEQ_IDLE: if (accept_c) seq_d = SEQ_HI;
         SEQ_HI:   if (done_c) seq_d = SEQ_LO;
         SEQ_LO:   if (done_c) seq_d = is_long_cmd(byte_q) ? SEQ_WAIT : SEQ_IDLE;
         SEQ_WAIT: if (done_c) seq_d = SEQ_IDLE;
         default:  seq_d = SEQ_IDLE;
      endcase
   end

   // Grant and nibble-start decode; the high nibble launches straight from the request.
   always_comb begin
      grant0_c     = 1'b0;
      grant1_c     = 1'b0;
      start_c      = 1'b0;
      wait_start_c = 1'b0;
      nib_c        = '0;
      nib_rs_c     = 1'b0;
      if (rst_n && init_done && (seq_q == SEQ_IDLE)) begin
         grant0_c = req.req0_valid && (!req.req1_valid || last_q);
         grant1_c = req.req1_valid && (!req.req0_valid || !last_q);
      end
      case (seq_q)
`ifdef LCD_SCHED_INIT_EN
         SEQ_INIT: if ((init_idx_q == 3'd0) ||
                       (done_c && (init_idx_q != 3'(INIT_NIBBLES)))) begin
            start_c = 1'b1;
            nib_c   = init_nibble(init_idx_q[1:0]);
         end
`endif
         SEQ_IDLE: if (grant0_c || grant1_c) begin
            start_c  = 1'b1;
            nib_c    = grant1_c ? req.req1_data[7:4] : req.req0_data[7:4];
            nib_rs_c = grant1_c ? req.req1_rs : req.req0_rs;
         end
         SEQ_HI: if (done_c) begin
            start_c  = 1'b1;
            nib_c    = byte_q.data[3:0];
            nib_rs_c = byte_q.rs;
         end
         SEQ_LO: wait_start_c = done_c && is_long_cmd(byte_q);
         default: ;
      endcase
   end

   assign accept_c       = grant0_c || grant1_c;
   assign req.req0_ready = grant0_c;
   assign req.req1_ready = grant1_c;
   assign busy           = !rst_n || (seq_q != SEQ_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_q <= '0;
         last_q <= 1'b1;
      end else if (accept_c) begin
         byte_q.rs   <= grant1_c ? req.req1_rs   : req.req0_rs;
         byte_q.data <= grant1_c ? req.req1_data : req.req0_data;
         last_q      <= grant1_c;
      end
   end

`ifdef LCD_SCHED_INIT_EN
   // init_idx counts nibbles launched; init_done rises as the last GAP ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_idx_q  <= '0;
         init_done_q <= 1'b0;
      end else begin
         if ((seq_q == SEQ_INIT) && start_c) init_idx_q <= init_idx_q + 3'd1;
         if ((seq_q == SEQ_INIT) && (seq_d == SEQ_IDLE)) init_done_q <= 1'b1;
      end
   end
   assign init_done = init_done_q;
`else
   assign init_done = 1'b1;
`endif

   lcd_nibble_strobe #(
      .E_HIGH_CYCLES    (E_HIGH_CYCLES),
      .GAP_CYCLES       (GAP_CYCLES),
      .LONG_WAIT_CYCLES (LONG_WAIT_CYCLES),
      .CNT_W            (CNT_W)
   ) u_strobe (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_c),
      .nib        (nib_c),
      .nib_rs     (nib_rs_c),
      .wait_start (wait_start_c),
      .lcd_d      (lcd_d),
      .lcd_rs     (lcd_rs),
      .lcd_e      (lcd_e),
      .done_c     (done_c)
   );

endmodule
